// File: rtl/gf2k_pkg.sv
// Shared definitions for the sequential GF(2^k) ALU: operation codes,
// controller states and the latency figures that callers plan around.
package gf2k_pkg;

  localparam logic [1:0] MODE_ADD = 2'd0;
  localparam logic [1:0] MODE_SUB = 2'd1;
  localparam logic [1:0] MODE_MUL = 2'd2;
  localparam logic [1:0] MODE_DIV = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    XOR,
    MUL,
    SQR,
    DMUL,
    DONE
  } state_t;

  // Cycles from the accepting edge to the edge that raises out_valid.
  localparam int LAT_SHORT = 1;

  function automatic int lat_mul(input int deg);
    return deg + 1;
  endfunction

  function automatic int lat_div(input int deg);
    return 2 * (deg - 1) * deg + 1;
  endfunction

endpackage

// File: rtl/gf2k_mul_serial.sv
// Bit-serial GF(2^DEG) multiplier, MSB-first shift-and-add. The first step
// is folded into the start edge so done pulses exactly DEG cycles after start.
module gf2k_mul_serial #(
  parameter int DEG = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [DEG:0]   poly,
  input  logic [DEG-1:0] a,
  input  logic [DEG-1:0] b,
  output logic           done,
  output logic [DEG-1:0] p
);

  localparam int CNT_W = $clog2(DEG + 1);

  logic [DEG-1:0] a_q;
  logic [DEG-1:0] b_q;
  logic [DEG-1:0] red_q;
  logic [DEG-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic           run_q;
  logic           done_q;
  logic [DEG-1:0] red_in;

  // One shift-and-add step: multiply acc by x, reduce, then add a if the bit is set.
  function automatic logic [DEG-1:0] step(input logic [DEG-1:0] acc,
                                          input logic [DEG-1:0] red,
                                          input logic [DEG-1:0] addend,
                                          input logic           bit_i);
    logic [DEG-1:0] t;
    t = {acc[DEG-2:0], 1'b0} ^ (acc[DEG-1] ? red : '0);
    return bit_i ? (t ^ addend) : t;
  endfunction

  // Reduction term is poly without its leading x^DEG; a non-monic poly reduces nothing
  // (the controller never starts a product with one).
  assign red_in = poly[DEG-1:0] & {DEG{poly[DEG]}};

  // Operand capture on start, then one multiplier bit per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      red_q  <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else if (start) begin
      // NOTE: state registers use non-blocking assignments so every flop samples
      // pre-edge values regardless of statement order.
      a_q    <= a;
      b_q    <= {b[DEG-2:0], 1'b0};
      red_q  <= red_in;
      acc_q  <= step('0, red_in, a, b[DEG-1]);
      cnt_q  <= CNT_W'(1);
      run_q  <= 1'b1;
      done_q <= 1'b0;
    end else if (run_q) begin
      acc_q <= step(acc_q, red_q, a_q, b_q[DEG-1]);
      b_q   <= {b_q[DEG-2:0], 1'b0};
      cnt_q <= cnt_q + CNT_W'(1);
      if (cnt_q == CNT_W'(DEG - 1)) begin
        run_q  <= 1'b0;
        done_q <= 1'b1;
      end else begin
        done_q <= 1'b0;
      end
    end else begin
      done_q <= 1'b0;
    end
  end

  assign done = done_q;
  assign p    = acc_q;

endmodule

// File: rtl/gf2k_seq_alu.sv
// Sequential GF(2^DEG) ALU with per-transaction operation and field polynomial.
// Division runs Fermat inversion (DEG-1 square/multiply rounds) on the one
// shared bit-serial multiplier; each new product is launched in the cycle the
// previous one completes, so rounds cost exactly DEG cycles each.
module gf2k_seq_alu
  import gf2k_pkg::*;
#(
  parameter int DEG = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  input  logic [1:0]     mode,
  input  logic [DEG:0]   poly,
  input  logic [DEG-1:0] in1,
  input  logic [DEG-1:0] in2,
  output logic           busy,
  output logic           out_valid,
  output logic [DEG-1:0] result,
  output logic           err
);

  localparam int CNT_W = $clog2(DEG + 1);

  state_t         state;
  state_t         next_state;
  logic [DEG:0]   poly_r;
  logic [DEG-1:0] r_r;      // in1, then the running quotient for div
  logic [DEG-1:0] s_r;      // in2, then the running power of in2 for div
  logic [DEG-1:0] res_r;
  logic           err_r;
  logic [CNT_W-1:0] iter_r;
  logic           launch_r; // first cycle of a MUL or SQR sequence

  logic           bad_in;
  logic           last_iter;
  logic           mul_start;
  logic [DEG-1:0] mul_a;
  logic [DEG-1:0] mul_b;
  logic           mul_done;
  logic [DEG-1:0] mul_p;

  assign bad_in    = !poly[DEG] || ((mode == MODE_DIV) && (in2 == '0));
  assign last_iter = (iter_r == CNT_W'(DEG - 2));

  gf2k_mul_serial #(.DEG(DEG)) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .start (mul_start),
    .poly  (poly_r),
    .a     (mul_a),
    .b     (mul_b),
    .done  (mul_done),
    .p     (mul_p)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic. Error transactions take the one-cycle XOR path so every
  // short transaction has the same latency.
  always_comb begin
    // NOTE: default first so every path assigns next_state and no latch is inferred.
    next_state = state;
    case (state)
      IDLE: begin
        if (in_valid) begin
          if (bad_in) begin
            next_state = XOR;
          end else begin
            case (mode)
              MODE_ADD, MODE_SUB: next_state = XOR;
              MODE_MUL:           next_state = MUL;
              MODE_DIV:           next_state = SQR;
            endcase
          end
        end
      end
      XOR:  next_state = DONE;
      MUL:  if (mul_done) next_state = DONE;
      SQR:  if (mul_done) next_state = DMUL;
      DMUL: if (mul_done) next_state = last_iter ? DONE : SQR;
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Operand latching and write-back of each completed product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      poly_r   <= '0;
      r_r      <= '0;
      s_r      <= '0;
      res_r    <= '0;
      err_r    <= 1'b0;
      iter_r   <= '0;
      launch_r <= 1'b0;
    end else begin
      launch_r <= (state == IDLE) && in_valid && !bad_in &&
                  ((mode == MODE_MUL) || (mode == MODE_DIV));
      case (state)
        IDLE: begin
          if (in_valid) begin
            poly_r <= poly;
            r_r    <= in1;
            s_r    <= in2;
            err_r  <= bad_in;
            iter_r <= '0;
            res_r  <= '0;
          end
        end
        XOR:  res_r <= err_r ? '0 : (r_r ^ s_r);
        MUL:  if (mul_done) res_r <= mul_p;
        SQR:  if (mul_done) s_r <= mul_p;
        DMUL: begin
          if (mul_done) begin
            r_r    <= mul_p;
            iter_r <= iter_r + CNT_W'(1);
            if (last_iter) res_r <= mul_p;
          end
        end
        default: ;
      endcase
    end
  end

  // Multiplier launch and operand steering. Chained launches take the fresh
  // product straight from the multiplier output.
  always_comb begin
    mul_start = launch_r ||
                (mul_done && ((state == SQR) || ((state == DMUL) && !last_iter)));
    mul_a = s_r;
    mul_b = s_r;
    case (state)
      MUL: begin
        mul_a = r_r;
        mul_b = s_r;
      end
      SQR: begin
        if (!launch_r) begin
          mul_a = r_r;
          mul_b = mul_p;
        end
      end
      default: ;
    endcase
  end

  // Outputs are decoded from state; result and err are forced low outside DONE.
  always_comb begin
    busy      = (state != IDLE);
    out_valid = (state == DONE);
    result    = out_valid ? res_r : '0;
    err       = out_valid && err_r;
  end

endmodule

// File: tb/tb_gf2k_seq_alu.sv
// Directed bench for gf2k_seq_alu at DEG=4 (poly x^4+x+1) and DEG=8 (poly 0x11B).
module tb_gf2k_seq_alu;
  import gf2k_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       in_valid;
  logic [1:0] mode;
  logic [4:0] poly;
  logic [3:0] in1, in2;
  logic       busy, out_valid, err;
  logic [3:0] result;

  logic       v8;
  logic [1:0] mode8;
  logic [8:0] poly8;
  logic [7:0] a8, b8;
  logic       busy8, ov8, err8;
  logic [7:0] res8;

  gf2k_seq_alu #(.DEG(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .mode(mode), .poly(poly),
    .in1(in1), .in2(in2), .busy(busy), .out_valid(out_valid), .result(result), .err(err)
  );

  gf2k_seq_alu #(.DEG(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .mode(mode8), .poly(poly8),
    .in1(a8), .in2(b8), .busy(busy8), .out_valid(ov8), .result(res8), .err(err8)
  );

  int total = 0;
  int bad = 0;
  int t_lat, t_res, t_err, t_busy_ok;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // LSB-first multiply with full-polynomial reduction.
  function automatic int ref_mul(input int a, input int b, input int p, input int deg);
    int r = 0;
    int x = a;
    for (int i = 0; i < deg; i++) begin
      if (((b >> i) & 1) != 0) r ^= x;
      x = x << 1;
      if (((x >> deg) & 1) != 0) x ^= p;
    end
    return r & ((1 << deg) - 1);
  endfunction

  // Division by exhaustive search for the x with b*x = a.
  function automatic int ref_div(input int a, input int b, input int p, input int deg);
    for (int x = 0; x < (1 << deg); x++)
      if (ref_mul(b, x, p, deg) == a) return x;
    return -1;
  endfunction

  // One DEG=4 transaction; optional ignored in_valid pulses at cycles 2, 3, 10.
  task automatic run4(input logic [1:0] m, input logic [4:0] p, input logic [3:0] x,
                      input logic [3:0] y, input bit noisy);
    @(posedge clk); #1;
    mode = m; poly = p; in1 = x; in2 = y; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    t_busy_ok = (busy && !out_valid) ? 1 : 0;
    t_lat = 0; t_res = 0; t_err = 0;
    if (noisy) begin
      mode = MODE_MUL; in1 = 4'hF; in2 = 4'h3;
    end
    for (int k = 1; k <= 300 && t_lat == 0; k++) begin
      in_valid = noisy && (k == 2 || k == 3 || k == 10);
      @(posedge clk); #1;
      if (!busy) t_busy_ok = 0;
      if (out_valid) begin
        t_lat = k; t_res = int'(result); t_err = int'(err);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic run8(input logic [1:0] m, input logic [7:0] x, input logic [7:0] y);
    @(posedge clk); #1;
    mode8 = m; poly8 = 9'h11B; a8 = x; b8 = y; v8 = 1'b1;
    @(posedge clk); #1;
    v8 = 1'b0;
    t_lat = 0; t_res = 0; t_err = 0;
    for (int k = 1; k <= 400 && t_lat == 0; k++) begin
      @(posedge clk); #1;
      if (ov8) begin
        t_lat = k; t_res = int'(res8); t_err = int'(err8);
      end
    end
  endtask

  initial begin
    int a, b, q, seen_ov;
    in_valid = 1'b0; mode = 2'd0; poly = 5'h13; in1 = '0; in2 = '0;
    v8 = 1'b0; mode8 = 2'd0; poly8 = 9'h11B; a8 = '0; b8 = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_err", err, 0);
    check("rst_busy8", busy8, 0);
    rst_n = 1'b1;

    // add / sub
    run4(MODE_ADD, 5'h13, 4'hA, 4'h6, 0);
    check("add_lat", t_lat, LAT_SHORT);
    check("add_res", t_res, 32'hC);
    check("add_err", t_err, 0);
    check("add_busy", t_busy_ok, 1);
    @(posedge clk); #1;
    check("idle_out_valid", out_valid, 0);
    check("idle_result", result, 0);
    run4(MODE_SUB, 5'h13, 4'hA, 4'h6, 0);
    check("sub_res", t_res, 32'hC);
    check("sub_lat", t_lat, LAT_SHORT);

    // mul
    run4(MODE_MUL, 5'h13, 4'h7, 4'h5, 0);
    check("mul_lat", t_lat, lat_mul(4));
    check("mul_res", t_res, 32'h8);
    check("mul_busy", t_busy_ok, 1);
    check("mul_err", t_err, 0);

    // div
    run4(MODE_DIV, 5'h13, 4'h8, 4'h5, 0);
    check("div_lat", t_lat, lat_div(4));
    check("div_res", t_res, 32'h7);
    check("div_busy", t_busy_ok, 1);
    run4(MODE_DIV, 5'h13, 4'h1, 4'h2, 0);
    check("inv2_res", t_res, 32'h9);

    // error cases
    run4(MODE_DIV, 5'h13, 4'h8, 4'h0, 0);
    check("div0_lat", t_lat, LAT_SHORT);
    check("div0_err", t_err, 1);
    check("div0_res", t_res, 0);
    run4(MODE_MUL, 5'h03, 4'h7, 4'h5, 0);
    check("badpoly_lat", t_lat, LAT_SHORT);
    check("badpoly_err", t_err, 1);
    check("badpoly_res", t_res, 0);

    // in_valid while busy is ignored; back-to-back issue right after out_valid
    run4(MODE_DIV, 5'h13, 4'h8, 4'h5, 1);
    check("noisy_lat", t_lat, lat_div(4));
    check("noisy_res", t_res, 32'h7);
    run4(MODE_ADD, 5'h13, 4'h3, 4'h5, 0);
    check("b2b_lat", t_lat, LAT_SHORT);
    check("b2b_res", t_res, 32'h6);

    // asynchronous reset in the middle of a div
    @(posedge clk); #1;
    mode = MODE_DIV; poly = 5'h13; in1 = 4'h8; in2 = 4'h5; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("mid_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_out_valid", out_valid, 0);
    check("arst_result", result, 0);
    check("arst_err", err, 0);
    seen_ov = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (out_valid) seen_ov = 1;
      if (k == 3) rst_n = 1'b1;
    end
    check("arst_no_out_valid", seen_ov, 0);
    run4(MODE_MUL, 5'h13, 4'h7, 4'h5, 0);
    check("post_rst_mul", t_res, 32'h8);
    check("post_rst_lat", t_lat, lat_mul(4));

    // DEG=4 random mul/div against the model
    for (int i = 0; i < 10; i++) begin
      a = int'($urandom_range(0, 15));
      b = int'($urandom_range(1, 15));
      run4(MODE_MUL, 5'h13, 4'(a), 4'(b), 0);
      check("rnd4_mul", t_res, ref_mul(a, b, 5'h13, 4));
      run4(MODE_DIV, 5'h13, 4'(a), 4'(b), 0);
      check("rnd4_div", t_res, ref_div(a, b, 5'h13, 4));
    end

    // DEG=4: a*(b/a) = b for every nonzero a
    for (int i = 1; i < 16; i++) begin
      b = int'($urandom_range(0, 15));
      run4(MODE_DIV, 5'h13, 4'(b), 4'(i), 0);
      q = t_res;
      run4(MODE_MUL, 5'h13, 4'(i), 4'(q), 0);
      check("rnd4_roundtrip", t_res, b);
    end

    // DEG=8
    run8(MODE_MUL, 8'h57, 8'h83);
    check("d8_mul_fips", t_res, 32'hC1);
    check("d8_mul_lat", t_lat, lat_mul(8));
    run8(MODE_DIV, 8'h01, 8'h53);
    check("d8_inv_53", t_res, 32'hCA);
    check("d8_div_lat", t_lat, lat_div(8));
    run8(MODE_DIV, 8'h12, 8'h00);
    check("d8_div0_err", t_err, 1);
    check("d8_div0_res", t_res, 0);
    for (int i = 0; i < 10; i++) begin
      a = int'($urandom_range(0, 255));
      b = int'($urandom_range(1, 255));
      run8(MODE_MUL, 8'(a), 8'(b));
      check("rnd8_mul", t_res, ref_mul(a, b, 9'h11B, 8));
      run8(MODE_ADD, 8'(a), 8'(b));
      check("rnd8_add", t_res, a ^ b);
    end
    for (int i = 0; i < 5; i++) begin
      a = int'($urandom_range(1, 255));
      b = int'($urandom_range(0, 255));
      run8(MODE_DIV, 8'(b), 8'(a));
      q = t_res;
      check("rnd8_div", q, ref_div(b, a, 9'h11B, 8));
      run8(MODE_MUL, 8'(a), 8'(q));
      check("rnd8_roundtrip", t_res, b);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
